alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 32-bit ripple ALU (thirty_two_alu).
- Captures the ALU's per-beat result: sum/out, cout, operand MSBs and control.
- Performs final result selection, including computing set-less-than, which the ALU's mux leg leaves unconnected.
- Generates zero/negative/carry/overflow flags.
- Presents results through a valid/ready handshake with a 2-entry skid buffer, so downstream backpressure never drops a beat.

Parameters:
WIDTH, 32, datapath width; flags reference bit WIDTH-1 as MSB

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU beat present
in_ready  output  1  stage can accept a beat this cycle
in_op  input  2  {op1,op2}: 00 AND, 01 SUM, 10 OR, 11 SLT
in_sub  input  1  subtract control the ALU used for this beat
in_a_msb  input  1  a[WIDTH-1] fed to ALU
in_b_msb  input  1  b[WIDTH-1] fed to ALU (before inversion)
in_sum  input  WIDTH  ALU sum bus
in_out  input  WIDTH  ALU mux output bus
in_cout  input  1  ALU carry out
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  final result
out_zero  output  1  out_result == 0
out_neg  output  1  out_result[WIDTH-1]
out_carry  output  1  carry flag
out_ovf  output  1  signed overflow flag

Behaviour:
- Reset (async, immediate): both entries invalid; out_valid=0; in_ready=1 after deassert; out_result=0; all flags 0.
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Result selection, computed combinationally on input and stored:
  - AND (00) and OR (10): result = in_out.
  - SUM (01): result = in_sum.
  - SLT (11): result = {WIDTH-1 zeros, in_sum[WIDTH-1] ^ ovf}; in_out is ignored.
- Overflow: b_eff = in_b_msb ^ in_sub; ovf = (in_a_msb == b_eff) && (in_sum[WIDTH-1] != in_a_msb).
  - out_ovf = ovf for SUM.
  - out_ovf = 0 for AND, OR and SLT.
- Carry: out_carry = in_cout for SUM and SLT; 0 for AND and OR.
- out_zero and out_neg are always derived from the stored final result.
- Storage: main register drives the outputs; skid register is the second entry.
  - in_ready is registered and equals !skid_valid.
  - Accept with main empty, or main being delivered this cycle and skid empty: load main.
  - Accept with main full and not delivered: load skid.
  - Deliver with skid valid: main <= skid, skid_valid <= 0.
  - Accept and deliver in the same cycle with skid valid cannot occur, because in_ready=0.
- Latency: accepted beat appears on out_valid the next cycle when main is empty or draining.
- Sustained throughput with out_ready=1: one beat per cycle.
- Ordering strictly FIFO; no beat is dropped or duplicated.
- Outputs are stable while out_valid && !out_ready.
- in_* values are don't-care when not accepted.
- Reset mid-operation discards both entries; no partial beat is emitted.

Test Plan:
1. Assert rst with random inputs -> out_valid=0, out_result=0, all flags 0; one cycle after deassert in_ready=1.
2. SUM, sub=1, a=40, b=10: in_sum=30, in_cout=1, a_msb=0, b_msb=0, out_ready=1 -> next cycle out_valid=1, result=30, zero=0, neg=0, carry=1, ovf=0.
3. SUM, sub=0, a=0x7FFFFFFF, b=1: in_sum=0x80000000, cout=0 -> result=0x80000000, neg=1, ovf=1, carry=0. Then AND with in_out=0 -> zero=1, carry=0, ovf=0.
4. SLT, sub=1, a=10, b=40: in_sum=0xFFFFFFE2 -> result=1. Then SLT with a=40, b=10, in_sum=30 -> result=0, zero=1.
5. out_ready=0, drive three valid beats R1, R2, R3:
   - R1 and R2 are accepted; in_ready=0 from the cycle after R2; R3 is held.
   - Then raise out_ready -> R1, R2, R3 delivered in order, out_result stable while stalled, no duplicates.
6. Fill both entries, assert rst mid-stall -> out_valid=0 immediately, in_ready=1 after release, and the next accepted beat is the first one delivered.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage behind the 32-bit ripple ALU.
// Selects the final result, including set-less-than, and computes the
// zero/negative/carry/overflow flags. Results are presented through a
// valid/ready handshake backed by a two-entry skid buffer (main + skid), so a
// stalled consumer never causes a beat to be lost.
module alu_result_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_sub,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_out,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf
);

   // Operation encoding as presented by the ALU's {op1,op2} controls.
   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_SUM = 2'b01,
      OP_OR  = 2'b10,
      OP_SLT = 2'b11
   } op_e;

   // One stored beat: final result plus its flags.
   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             neg;
      logic             carry;
      logic             ovf;
   } beat_t;

   beat_t new_beat;
   beat_t main_q;
   beat_t skid_q;

   logic  main_valid;
   logic  skid_valid;
   logic  main_valid_d;
   logic  skid_valid_d;

   logic  b_eff;
   logic  sum_ovf;
   logic  accept;
   logic  deliver;
   logic  load_main;
   logic  load_skid;
   logic  shift;

   // Signed overflow of the ALU add/subtract, judged from operand and sum MSBs.
   assign b_eff   = in_b_msb ^ in_sub;
   assign sum_ovf = (in_a_msb == b_eff) && (in_sum[WIDTH-1] != in_a_msb);

   // Final result selection and flag generation for the incoming beat.
   always_comb begin
      // NOTE: every field gets a default first so no path through the case
      // statement leaves a value unassigned and infers a latch.
      new_beat = '0;
      unique case (op_e'(in_op))
         OP_AND, OP_OR: begin
            new_beat.result = in_out;
         end
         OP_SUM: begin
            new_beat.result = in_sum;
            new_beat.carry  = in_cout;
            new_beat.ovf    = sum_ovf;
         end
         OP_SLT: begin
            // The ALU's mux leg for SLT is unconnected; the true sign of a-b
            // is the sum MSB corrected by overflow.
            new_beat.result = {{(WIDTH-1){1'b0}}, in_sum[WIDTH-1] ^ sum_ovf};
            new_beat.carry  = in_cout;
         end
      endcase
      // zero/neg are derived from the final result, captured with it so that
      // the reset state shows all flags clear.
      new_beat.zero = (new_beat.result == '0);
      new_beat.neg  = new_beat.result[WIDTH-1];
   end

   // Handshake decode: where the accepted beat goes and whether skid drains.
   assign accept    = in_valid && in_ready;
   assign deliver   = main_valid && out_ready;
   assign shift     = deliver && skid_valid;
   assign load_main = accept && (!main_valid || deliver);
   assign load_skid = accept && main_valid && !deliver;

   // Next occupancy of the two entries.
   always_comb begin
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
      if (shift) begin
         main_valid_d = 1'b1;
         skid_valid_d = 1'b0;
      end else if (load_main) begin
         main_valid_d = 1'b1;
      end else if (load_skid) begin
         skid_valid_d = 1'b1;
      end else if (deliver) begin
         main_valid_d = 1'b0;
      end
   end

   // Occupancy flags and the registered in_ready (low only while skid is full).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         in_ready   <= !skid_valid_d;
      end
   end

   // Main entry payload; drives the outputs, so it is cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
      end else if (shift) begin
         main_q <= skid_q;
      end else if (load_main) begin
         main_q <= new_beat;
      end
   end

   // Skid entry payload.
   always_ff @(posedge clk) begin
      // NOTE: the skid payload is deliberately not reset; it is only ever
      // read when skid_valid is set, and skid_valid is reset.
      if (load_skid) begin
         skid_q <= new_beat;
      end
   end

   assign out_valid  = main_valid;
   assign out_result = main_q.result;
   assign out_zero   = main_q.zero;
   assign out_neg    = main_q.neg;
   assign out_carry  = main_q.carry;
   assign out_ovf    = main_q.ovf;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed cases followed by a
// randomized run, checked against a queue-based reference model that derives
// results and flags from integer arithmetic on the ALU operands.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic        in_sub;
   logic        in_a_msb;
   logic        in_b_msb;
   logic [31:0] in_sum;
   logic [31:0] in_out;
   logic        in_cout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_neg;
   logic        out_carry;
   logic        out_ovf;

   alu_result_stage #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_sub     (in_sub),
      .in_a_msb   (in_a_msb),
      .in_b_msb   (in_b_msb),
      .in_sum     (in_sum),
      .in_out     (in_out),
      .in_cout    (in_cout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_carry  (out_carry),
      .out_ovf    (out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic        neg;
      logic        carry;
      logic        ovf;
   } exp_t;

   exp_t q[$];          // beats accepted but not yet delivered, oldest first
   exp_t pend;          // expected beat for the inputs currently driven
   bit   ready_known;   // one clock has passed since reset release
   int   n_assert = 0;
   int   n_fail   = 0;

   // Compare one observed value with its expected value.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: what the stage must present for an ALU op on full operands.
   function automatic exp_t ref_beat(input logic [1:0] op, input logic sub,
                                     input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb, full;
      logic [32:0] u;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      full = sub ? sa - sb : sa + sb;
      u    = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 33'(sub);
      e    = '0;
      case (op)
         2'b00: e.result = a & b;
         2'b10: e.result = a | b;
         2'b01: begin
            e.result = u[31:0];
            e.carry  = u[32];
            e.ovf    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
         end
         default: begin
            e.result = (full < 0) ? 32'd1 : 32'd0;
            e.carry  = u[32];
         end
      endcase
      e.zero = (e.result == 32'd0);
      e.neg  = e.result[31];
      return e;
   endfunction

   // Drive the buses a ripple ALU would produce for this op and operands.
   task automatic set_beat(input logic [1:0] op, input logic sub,
                           input logic [31:0] a, input logic [31:0] b);
      logic [32:0] u;
      u        = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 33'(sub);
      in_op    = op;
      in_sub   = sub;
      in_a_msb = a[31];
      in_b_msb = b[31];
      in_sum   = u[31:0];
      in_cout  = u[32];
      in_out   = (op == 2'b00) ? (a & b) : (op == 2'b10) ? (a | b) : $urandom();
      pend     = ref_beat(op, sub, a, b);
   endtask

   // One clock cycle, entered and left at a falling edge: check outputs
   // against the model, then advance the model by the handshakes that occur.
   task automatic step(input logic v, input logic rdy);
      bit acc, del;
      in_valid  = v;
      out_ready = rdy;
      #1;
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (ready_known) check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         check("result", out_result, q[0].result);
         check("zero", 32'(out_zero), 32'(q[0].zero));
         check("neg", 32'(out_neg), 32'(q[0].neg));
         check("carry", 32'(out_carry), 32'(q[0].carry));
         check("ovf", 32'(out_ovf), 32'(q[0].ovf));
      end
      acc = v && ready_known && (q.size() < 2);
      del = rdy && (q.size() > 0);
      @(posedge clk);
      if (del) void'(q.pop_front());
      if (acc) q.push_back(pend);
      ready_known = 1'b1;
      @(negedge clk);
   endtask

   // Check the cleared output state seen during reset.
   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_result"}, out_result, 32'd0);
      check({tag, "_flags"}, {28'd0, out_zero, out_neg, out_carry, out_ovf}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, corner [4];
      logic [1:0]  op;
      logic        sub, v, rdy;

      corner[0] = 32'h7FFF_FFFF;
      corner[1] = 32'h8000_0000;
      corner[2] = 32'h0000_0000;
      corner[3] = 32'hFFFF_FFFF;

      // 1: reset with random inputs
      rst         = 1'b1;
      ready_known = 1'b0;
      in_valid    = 1'($urandom());
      out_ready   = 1'($urandom());
      set_beat(2'($urandom()), 1'($urandom()), $urandom(), $urandom());
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      step(1'b0, 1'b1);   // in_ready is checked from the next step on

      // 2: SUM with subtract, 40 - 10
      set_beat(2'b01, 1'b1, 32'd40, 32'd10);
      step(1'b1, 1'b1);
      // 3: SUM overflow 0x7FFFFFFF + 1, then AND giving zero
      set_beat(2'b01, 1'b0, 32'h7FFF_FFFF, 32'd1);
      step(1'b1, 1'b1);
      set_beat(2'b00, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
      step(1'b1, 1'b1);
      // 4: SLT 10 < 40, then SLT 40 < 10
      set_beat(2'b11, 1'b1, 32'd10, 32'd40);
      step(1'b1, 1'b1);
      set_beat(2'b11, 1'b1, 32'd40, 32'd10);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // 5: stalled consumer, three offered beats; the third must wait
      set_beat(2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F00);
      step(1'b1, 1'b0);
      set_beat(2'b01, 1'b0, 32'd5, 32'd6);
      step(1'b1, 1'b0);
      set_beat(2'b11, 1'b1, 32'h8000_0000, 32'd1);
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // 6: both entries full, reset mid-stall
      set_beat(2'b01, 1'b0, 32'd100, 32'd200);
      step(1'b1, 1'b0);
      set_beat(2'b01, 1'b0, 32'd300, 32'd400);
      step(1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      q.delete();
      ready_known = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0);
      set_beat(2'b01, 1'b1, 32'd7, 32'd9);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // Randomized traffic with alternating backpressure phases
      for (int i = 0; i < 1500; i++) begin
         op  = 2'($urandom());
         sub = (op == 2'b11) ? 1'b1 : 1'($urandom());
         a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
         b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
         if ($urandom_range(0, 7) == 0) b = a;
         set_beat(op, sub, a, b);
         v   = ($urandom_range(0, 3) != 0);
         rdy = ((i % 300) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
         step(v, rdy);
      end
      repeat (4) step(1'b0, 1'b1);
      check("drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
